sdes_core: RTL and testbench

- Clocked Simplified-DES (S-DES) encryption core.
- Encrypts an 8-bit nonce under a 10-bit key and produces an 8-bit pseudo-random word `rn`.
- Used as a lightweight keyed random-number / challenge generator.
- One request at a time: valid-in/ready handshake, one-cycle `out_valid` pulse with the result.

---
 rtl/sdes_core.sv | 138 +++++++++++++
 tb/tb_sdes_core.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sdes_core.sv
// sdes_core: clocked Simplified-DES encryption of an 8-bit nonce under a
// 10-bit key. One request at a time, three cycles per result, with a
// single-cycle out_valid pulse when rn is updated.
//
// state  | meaning
// IDLE   | waiting for a request; in_ready high
// ROUND1 | first Feistel round with K1, followed by the half swap
// ROUND2 | second round with K2 and the final permutation into rn
module sdes_core (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] nonce,
  input  logic [9:0] key,
  output logic       in_ready,
  output logic [7:0] rn,
  output logic       out_valid
);

  typedef enum logic [1:0] {IDLE, ROUND1, ROUND2} state_t;

  // S-box contents packed row-major, entry (row*4+col) at the MSB end first
  localparam logic [31:0] S0_TBL = 32'h4EE4_27DE;
  localparam logic [31:0] S1_TBL = 32'h1B87_C493;

  state_t     state, state_nxt;
  logic [7:0] lr;
  logic [7:0] k1, k2;
  logic       load, do_r1, do_r2;

  logic [9:0] p10_key;
  logic [4:0] l1, r1, l3, r3;
  logic [7:0] k1_nxt, k2_nxt;

  function automatic logic [7:0] p8(input logic [9:0] x);
    p8 = {x[4], x[7], x[3], x[6], x[2], x[5], x[0], x[1]};
  endfunction

  function automatic logic [7:0] ip(input logic [7:0] b);
    ip = {b[6], b[2], b[5], b[7], b[4], b[0], b[3], b[1]};
  endfunction

  function automatic logic [7:0] ip_inv(input logic [7:0] b);
    ip_inv = {b[4], b[7], b[5], b[3], b[1], b[6], b[0], b[2]};
  endfunction

  function automatic logic [1:0] sbox(input logic [31:0] tbl, input logic [3:0] x);
    logic [3:0] idx;
    idx  = {x[3], x[0], x[2], x[1]};
    sbox = tbl[5'd30 - {idx, 1'b0} +: 2];
  endfunction

  function automatic logic [3:0] f_round(input logic [3:0] r, input logic [7:0] sk);
    logic [7:0] t;
    logic [3:0] y;
    t       = {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]} ^ sk;
    y       = {sbox(S0_TBL, t[7:4]), sbox(S1_TBL, t[3:0])};
    f_round = {y[2], y[0], y[1], y[3]};
  endfunction

  function automatic logic [7:0] fk(input logic [7:0] x, input logic [7:0] sk);
    fk = {x[7:4] ^ f_round(x[3:0], sk), x[3:0]};
  endfunction

  // Key schedule from the live key input; only used at acceptance
  always_comb begin
    p10_key = {key[7], key[5], key[8], key[3], key[6],
               key[0], key[9], key[1], key[2], key[4]};
    l1      = {p10_key[8:5], p10_key[9]};
    r1      = {p10_key[3:0], p10_key[4]};
    l3      = {l1[2:0], l1[4:3]};
    r3      = {r1[2:0], r1[4:3]};
    k1_nxt  = p8({l1, r1});
    k2_nxt  = p8({l3, r3});
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = ROUND1;
      ROUND1:  state_nxt = ROUND2;
      ROUND2:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decoded controls for the datapath
  always_comb begin
    in_ready = 1'b0;
    load     = 1'b0;
    do_r1    = 1'b0;
    do_r2    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        load     = in_valid;
      end
      ROUND1:  do_r1 = 1'b1;
      ROUND2:  do_r2 = 1'b1;
      default: ;
    endcase
  end

  // Working block and round keys, captured at acceptance so input changes
  // while busy cannot disturb the in-flight result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lr <= 8'h00;
      k1 <= 8'h00;
      k2 <= 8'h00;
    end else if (load) begin
      lr <= ip(nonce);
      k1 <= k1_nxt;
      k2 <= k2_nxt;
    end else if (do_r1) begin
      lr <= {fk(lr, k1)[3:0], fk(lr, k1)[7:4]};
    end
  end

  // Result register and completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rn        <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      out_valid <= do_r2;
      if (do_r2) rn <= ip_inv(fk(lr, k2));
    end
  end

endmodule

// File: tb/tb_sdes_core.sv
// tb_sdes_core: directed and randomized checks of sdes_core against a
// table-driven S-DES reference model.
module tb_sdes_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] nonce;
  logic [9:0] key;
  logic       in_ready;
  logic [7:0] rn;
  logic       out_valid;

  int vectors = 0;
  int miscompares = 0;

  sdes_core dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .nonce(nonce), .key(key),
    .in_ready(in_ready), .rn(rn), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Reference model: generic permutation over 1-based MSB-first positions
  int p10_t[$] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  int p8_t[$]  = '{6, 3, 7, 4, 8, 5, 10, 9};
  int ip_t[$]  = '{2, 6, 3, 1, 4, 8, 5, 7};
  int ipi_t[$] = '{4, 1, 3, 5, 7, 2, 8, 6};
  int ep_t[$]  = '{4, 1, 2, 3, 2, 3, 4, 1};
  int p4_t[$]  = '{2, 4, 3, 1};
  int s0_m[4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
  int s1_m[4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

  function automatic int permute(int x, int n_in, int tbl[$]);
    int r = 0;
    foreach (tbl[j]) r = (r << 1) | ((x >> (n_in - tbl[j])) & 1);
    return r;
  endfunction

  function automatic int rotl5(int h, int s);
    return ((h << s) | (h >> (5 - s))) & 31;
  endfunction

  function automatic int m_f(int r, int sk);
    int t, a, b, y;
    t = permute(r, 4, ep_t) ^ sk;
    a = (t >> 4) & 15;
    b = t & 15;
    y = s0_m[((a >> 3) & 1) * 2 + (a & 1)][(a >> 1) & 3] * 4
      + s1_m[((b >> 3) & 1) * 2 + (b & 1)][(b >> 1) & 3];
    return permute(y, 4, p4_t);
  endfunction

  function automatic logic [7:0] model(int n, int k);
    int p, l, r, k1, k2, x, hl, hr, tmp;
    p  = permute(k, 10, p10_t);
    l  = rotl5(p >> 5, 1);
    r  = rotl5(p & 31, 1);
    k1 = permute(l * 32 + r, 10, p8_t);
    l  = rotl5(l, 2);
    r  = rotl5(r, 2);
    k2 = permute(l * 32 + r, 10, p8_t);
    x  = permute(n, 8, ip_t);
    hl = (x >> 4) ^ m_f(x & 15, k1);
    hr = x & 15;
    tmp = hl; hl = hr; hr = tmp;
    hl = hl ^ m_f(hr, k2);
    return 8'(permute(hl * 16 + hr, 8, ipi_t));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request: wait for in_ready, hand it over, then check latency,
  // busy in_ready, result and single-cycle pulse
  task automatic run_req(input logic [7:0] n, input logic [9:0] k,
                         input logic [7:0] exp, input string tag);
    int lat;
    int guard;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1; nonce = n; key = k;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    nonce = 8'($urandom); key = 10'($urandom);
    lat = 1;
    while (!out_valid && lat < 10) begin
      chk({tag, "_busy"}, 32'(in_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    chk({tag, "_ov"}, 32'(out_valid), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_rn"}, 32'(rn), 32'(exp));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(out_valid), 32'd0);
    chk({tag, "_hold"}, 32'(rn), 32'(exp));
  endtask

  typedef struct { logic [7:0] n; logic [9:0] k; logic [7:0] c; } vec_t;
  vec_t std_v[$] = '{
    '{8'hff, 10'h3ff, 8'h0f}, '{8'h11, 10'h001, 8'hc3}, '{8'hb1, 10'h102, 8'hb0},
    '{8'hb1, 10'h1a2, 8'h1c}, '{8'hd2, 10'h1a2, 8'h49}, '{8'hd2, 10'h1b2, 8'h09},
    '{8'he4, 10'h2c2, 8'he3}, '{8'hf5, 10'h0c5, 8'h12}, '{8'h18, 10'h0d5, 8'h76}
  };

  initial begin
    logic [7:0] nr;
    logic [9:0] kr;

    // Reset with a request held pending
    rst = 1'b1; in_valid = 1'b1; nonce = 8'h00; key = 10'h000;
    repeat (3) begin
      @(negedge clk);
      chk("rst_rn", 32'(rn), 32'h00);
      chk("rst_ov", 32'(out_valid), 32'd0);
      chk("rst_rdy", 32'(in_ready), 32'd1);
    end
    rst = 1'b0; in_valid = 1'b0;
    run_req(8'h00, 10'h000, 8'hf0, "zero");

    // Standard vectors
    foreach (std_v[i]) run_req(std_v[i].n, std_v[i].k, std_v[i].c, $sformatf("std%0d", i));

    // Negative check
    run_req(8'h0a, 10'h010, model(8'h0a, 10'h010), "neg");
    vectors++;
    assert (rn !== 8'hf0) else begin
      miscompares++;
      $error("FAIL neg_not_f0: observed %0h expected not f0", rn);
    end

    // Back-to-back with nonce disturbed while busy
    @(negedge clk);
    in_valid = 1'b1; nonce = 8'hd2; key = 10'h1a2;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; nonce = 8'hff;
    @(negedge clk);
    nonce = 8'hff;
    @(negedge clk);
    chk("b2b_ov1", 32'(out_valid), 32'd1);
    chk("b2b_rn1", 32'(rn), 32'h49);
    chk("b2b_rdy", 32'(in_ready), 32'd1);
    in_valid = 1'b1; nonce = 8'hd2; key = 10'h1b2;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_gap1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("b2b_gap2", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("b2b_ov2", 32'(out_valid), 32'd1);
    chk("b2b_rn2", 32'(rn), 32'h09);

    // Busy rejection
    @(negedge clk);
    in_valid = 1'b1; nonce = 8'h18; key = 10'h0d5;
    @(posedge clk);
    @(negedge clk);
    chk("busy_rdy1", 32'(in_ready), 32'd0);
    nonce = 8'hb1; key = 10'h1a2;
    @(negedge clk);
    chk("busy_rdy2", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("busy_ov", 32'(out_valid), 32'd1);
    chk("busy_rn", 32'(rn), 32'h76);
    repeat (4) begin
      @(negedge clk);
      chk("busy_noq", 32'(out_valid), 32'd0);
    end
    chk("busy_hold", 32'(rn), 32'h76);

    // Reset during ROUND2
    @(negedge clk);
    in_valid = 1'b1; nonce = 8'hf5; key = 10'h0c5;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_rn", 32'(rn), 32'h00);
    chk("mrst_ov", 32'(out_valid), 32'd0);
    chk("mrst_rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mrst_nopulse", 32'(out_valid), 32'd0);
    end
    run_req(8'hf5, 10'h0c5, 8'h12, "mrst_again");

    // Randomized requests against the model
    for (int i = 0; i < 40; i++) begin
      nr = 8'($urandom);
      kr = 10'($urandom);
      run_req(nr, kr, model(nr, kr), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
